reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter with a registered write port.
// Define ARB_ROUND_ROBIN_EN for round-robin contention handling; otherwise loads always win.
module reg_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              busy_o,
    output logic [15:0]       write_count_o
);

    typedef enum logic {IDLE, WRITE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    state_t  state;
    logic    win1;
    logic    grant0, grant1, xfer;
    wr_req_t sel;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_ptr names the requester that wins the next contended cycle
    logic rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (grant0)
            rr_ptr <= 1'b1;
        else if (grant1)
            rr_ptr <= 1'b0;
    end

    assign win1 = rr_ptr;
`else
    assign win1 = 1'b1;
`endif

    always_comb begin
        grant0 = rst_n && !stall_i && req0_valid_i && !(req1_valid_i && win1);
        grant1 = rst_n && !stall_i && req1_valid_i && !(req0_valid_i && !win1);
        xfer   = grant0 || grant1;
        sel    = grant1 ? wr_req_t'{req1_addr_i, req1_data_i}
                        : wr_req_t'{req0_addr_i, req0_data_i};
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Address 0 is accepted and latched but never enables the write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rf_waddr_o    <= '0;
            rf_wdata_o    <= '0;
            write_count_o <= '0;
        end else if (xfer) begin
            rf_waddr_o <= sel.addr;
            rf_wdata_o <= sel.data;
            if (sel.addr != '0) begin
                state         <= WRITE;
                write_count_o <= write_count_o + 16'd1;
            end else begin
                state <= IDLE;
            end
        end else begin
            state <= IDLE;
        end
    end

    assign rf_we_o = (state == WRITE);
    assign busy_o  = rf_we_o;

endmodule
